// File: rtl/light_pattern_sequencer.sv
// light_pattern_sequencer: LED pattern generator (OFF/ALL/CHASE/ALT/BOUNCE)
// with step prescaler, chase direction and clean reload on mode change.
module light_pattern_sequencer #(
  parameter int NUM_LIGHTS = 4,
  parameter int TICK_DIV   = 4,
  parameter int DIV_W      = $clog2(TICK_DIV + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  dir,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  step_pulse
);

  localparam int MSB = NUM_LIGHTS - 1;

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_ALL    = 3'd1;
  localparam logic [2:0] ST_CHASE  = 3'd2;
  localparam logic [2:0] ST_ALT    = 3'd3;
  localparam logic [2:0] ST_BOUNCE = 3'd4;

  localparam logic [1:0] MD_ALL    = 2'b00;
  localparam logic [1:0] MD_CHASE  = 2'b01;
  localparam logic [1:0] MD_ALT    = 2'b10;
  localparam logic [1:0] MD_BOUNCE = 2'b11;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  function automatic logic [NUM_LIGHTS-1:0] alt_init();
    logic [NUM_LIGHTS-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_LIGHTS; i++) begin
      p[i] = ((i % 2) == 0);
    end
    return p;
  endfunction

  localparam logic [NUM_LIGHTS-1:0] PAT_ONES = '1;
  localparam logic [NUM_LIGHTS-1:0] PAT_LSB  = NUM_LIGHTS'(1);
  localparam logic [NUM_LIGHTS-1:0] PAT_MSB  = PAT_LSB << MSB;
  localparam logic [NUM_LIGHTS-1:0] PAT_ALT  = alt_init();

  logic [2:0]            state_q, state_d;
  logic [NUM_LIGHTS-1:0] lights_q, lights_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  pulse_q, pulse_d;
  logic                  bounce_up_q, bounce_up_d;

  logic [2:0]            req_state;
  logic [NUM_LIGHTS-1:0] init_pat;
  logic [NUM_LIGHTS-1:0] step_pat;
  logic                  step_up;
  logic                  load;
  logic                  step_due;

  // Map the mode input to its state and the pattern a load would show
  always_comb begin
    req_state = ST_ALL;
    init_pat  = PAT_ONES;
    unique case (mode)
      MD_ALL: begin
        req_state = ST_ALL;
        init_pat  = PAT_ONES;
      end
      MD_CHASE: begin
        req_state = ST_CHASE;
        init_pat  = dir ? PAT_MSB : PAT_LSB;
      end
      MD_ALT: begin
        req_state = ST_ALT;
        init_pat  = PAT_ALT;
      end
      MD_BOUNCE: begin
        req_state = ST_BOUNCE;
        init_pat  = PAT_LSB;
      end
      default: begin
        req_state = ST_ALL;
        init_pat  = PAT_ONES;
      end
    endcase
  end

  // Next pattern and bounce direction if a step is taken this cycle
  always_comb begin
    step_pat = lights_q;
    step_up  = bounce_up_q;
    unique case (state_q)
      ST_ALL: begin
        step_pat = lights_q;
      end
      ST_CHASE: begin
        if (dir) begin
          step_pat = {lights_q[0], lights_q[MSB:1]};
        end else begin
          step_pat = {lights_q[MSB-1:0], lights_q[MSB]};
        end
      end
      ST_ALT: begin
        step_pat = ~lights_q;
      end
      ST_BOUNCE: begin
        if (bounce_up_q) begin
          step_pat = lights_q << 1;
          step_up  = ~step_pat[MSB];
        end else begin
          step_pat = lights_q >> 1;
          step_up  = step_pat[0];
        end
      end
      default: begin
        step_pat = lights_q;
      end
    endcase
  end

  assign load     = enable & ((state_q == ST_OFF) | (state_q != req_state));
  assign step_due = (div_cnt_q == DIV_LAST);

  // Sequencer: disable beats load, load beats a due step
  always_comb begin
    state_d     = state_q;
    lights_d    = lights_q;
    div_cnt_d   = div_cnt_q;
    pulse_d     = 1'b0;
    bounce_up_d = bounce_up_q;
    unique case (1'b1)
      !enable: begin
        state_d   = ST_OFF;
        lights_d  = '0;
        div_cnt_d = '0;
      end
      load: begin
        state_d   = req_state;
        lights_d  = init_pat;
        div_cnt_d = '0;
        if (req_state == ST_BOUNCE) begin
          bounce_up_d = 1'b1;
        end
      end
      default: begin
        if (step_due) begin
          div_cnt_d   = '0;
          lights_d    = step_pat;
          bounce_up_d = step_up;
          pulse_d     = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State registers with asynchronous reset to the idle, dark state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_OFF;
      lights_q    <= '0;
      div_cnt_q   <= '0;
      pulse_q     <= 1'b0;
      bounce_up_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      lights_q    <= lights_d;
      div_cnt_q   <= div_cnt_d;
      pulse_q     <= pulse_d;
      bounce_up_q <= bounce_up_d;
    end
  end

  assign lights     = lights_q;
  assign step_pulse = pulse_q;

endmodule
